// File: rtl/rf_param.sv
// ---------------------------------------------------------------------------
// rf_param - parametrised register file with busy scoreboard
//
// Purpose:
//   NREGS x WIDTH register file for the multicycle datapath.
//   It has two combinational read ports and one synchronous write port.
//   Options:
//     - ZERO_R0: R0 is hardwired to zero.
//     - BYPASS: a read of the register being written returns dataw in the
//       same cycle.
//   A per-register busy bit tells the control FSM when a register still has
//   a write outstanding.
//
// Ports:
//   clock      in   1            rising-edge clock
//   reset      in   1            asynchronous active-low reset; clears all
//                                registers and busy bits
//   reg1/reg2  in   AW           read port addresses
//   regw       in   AW           write address
//   dataw      in   WIDTH        write data
//   RFWrite    in   1            write enable
//   mark       in   1            set busy bit of mark_reg
//   mark_reg   in   AW           register to mark busy
//   data1/2    out  WIDTH        read data for reg1/reg2
//   busy1/2    out  1            busy bit for reg1/reg2
//   regs_flat  out  NREGS*WIDTH  stored contents; R(i) at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module rf_param #(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 4,
  parameter int AW      = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AW-1:0]          reg1,
  input  logic [AW-1:0]          reg2,
  input  logic [AW-1:0]          regw,
  input  logic [WIDTH-1:0]       dataw,
  input  logic                   RFWrite,
  input  logic                   mark,
  input  logic [AW-1:0]          mark_reg,
  output logic [WIDTH-1:0]       data1,
  output logic [WIDTH-1:0]       data2,
  output logic                   busy1,
  output logic                   busy2,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr_en;
  logic mk_en;

  // An address is usable when it names a real register.
  // Under ZERO_R0, R0 is not usable either; it behaves like an absent register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign wr_en = RFWrite && addr_ok(regw);
  assign mk_en = mark && addr_ok(mark_reg);

  // Next-state: the write clears busy first; a mark applied after it wins,
  // because a new pending operation supersedes the one just completed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (int'(regw) == i)) begin
        regs_d[i] = dataw;
        busy_d[i] = 1'b0;
      end
      if (mk_en && (int'(mark_reg) == i)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is built from flops, not a RAM macro.
      // Clearing it on reset is part of its behaviour, so every entry is
      // reset explicitly here.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every flop
      // samples its pre-edge inputs.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1.
  // Absent registers (and R0 under ZERO_R0) read as 0 and not busy.
  always_comb begin
    data1 = '0;
    busy1 = 1'b0;
    if (addr_ok(reg1)) begin
      if ((BYPASS != 0) && wr_en && (regw == reg1)) begin
        data1 = dataw;
        busy1 = 1'b0;
      end else begin
        data1 = regs_q[reg1];
        busy1 = busy_q[reg1];
      end
    end
  end

  // Read port 2, identical rules to port 1.
  always_comb begin
    data2 = '0;
    busy2 = 1'b0;
    if (addr_ok(reg2)) begin
      if ((BYPASS != 0) && wr_en && (regw == reg2)) begin
        data2 = dataw;
        busy2 = 1'b0;
      end else begin
        data2 = regs_q[reg2];
        busy2 = busy_q[reg2];
      end
    end
  end

  // Debug view of stored state only; it is never bypassed.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!((ZERO_R0 != 0) && (i == 0))) begin
        regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// ---------------------------------------------------------------------------
// tb_rf_param - self-checking bench for rf_param
//
// Three configurations share one stimulus stream:
//   cfg 0: WIDTH=16 NREGS=8 AW=3 ZERO_R0=0 BYPASS=0
//   cfg 1: WIDTH=16 NREGS=8 AW=3 ZERO_R0=1 BYPASS=1
//   cfg 2: WIDTH=8  NREGS=5 AW=3 ZERO_R0=0 BYPASS=1
// A behavioural model of each file is compared against every output on each
// falling edge. Directed checks with literal values pin the model.
// ---------------------------------------------------------------------------
module tb_rf_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  reg1 = '0, reg2 = '0, regw = '0, mark_reg = '0;
  logic [15:0] dataw = '0;
  logic        RFWrite = 1'b0, mark = 1'b0;

  logic [15:0]  d1_a, d2_a, d1_b, d2_b;
  logic [7:0]   d1_c, d2_c;
  logic         b1_a, b2_a, b1_b, b2_b, b1_c, b2_c;
  logic [127:0] rf_a, rf_b;
  logic [39:0]  rf_c;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  rf_param #(.WIDTH(16), .NREGS(8), .AW(3), .ZERO_R0(0), .BYPASS(0)) u_a (
    .clock(clock), .reset(reset), .reg1(reg1), .reg2(reg2), .regw(regw),
    .dataw(dataw), .RFWrite(RFWrite), .mark(mark), .mark_reg(mark_reg),
    .data1(d1_a), .data2(d2_a), .busy1(b1_a), .busy2(b2_a), .regs_flat(rf_a));

  rf_param #(.WIDTH(16), .NREGS(8), .AW(3), .ZERO_R0(1), .BYPASS(1)) u_b (
    .clock(clock), .reset(reset), .reg1(reg1), .reg2(reg2), .regw(regw),
    .dataw(dataw), .RFWrite(RFWrite), .mark(mark), .mark_reg(mark_reg),
    .data1(d1_b), .data2(d2_b), .busy1(b1_b), .busy2(b2_b), .regs_flat(rf_b));

  rf_param #(.WIDTH(8), .NREGS(5), .AW(3), .ZERO_R0(0), .BYPASS(1)) u_c (
    .clock(clock), .reset(reset), .reg1(reg1), .reg2(reg2), .regw(regw),
    .dataw(dataw[7:0]), .RFWrite(RFWrite), .mark(mark), .mark_reg(mark_reg),
    .data1(d1_c), .data2(d2_c), .busy1(b1_c), .busy2(b2_c), .regs_flat(rf_c));

  // ---------------- behavioural model ----------------
  int cw [3] = '{16, 16, 8};
  int cn [3] = '{8, 8, 5};
  int cz [3] = '{0, 1, 0};
  int cb [3] = '{0, 1, 1};

  logic [15:0] m_reg  [3][8];
  logic        m_busy [3][8];

  function automatic logic [15:0] mask(int c);
    return (cw[c] == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic logic usable(int c, logic [2:0] a);
    return (int'(a) < cn[c]) && !(cz[c] != 0 && a == 3'd0);
  endfunction

  function automatic logic [15:0] exp_data(int c, logic [2:0] a);
    if (!usable(c, a)) return 16'h0;
    if (cb[c] != 0 && RFWrite && usable(c, regw) && regw == a) return dataw & mask(c);
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [2:0] a);
    if (!usable(c, a)) return 1'b0;
    if (cb[c] != 0 && RFWrite && usable(c, regw) && regw == a) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic [127:0] exp_flat(int c);
    logic [127:0] f = '0;
    for (int i = 0; i < cn[c]; i++) begin
      if (!(cz[c] != 0 && i == 0))
        f = f | (128'(m_reg[c][i] & mask(c)) << (i * cw[c]));
    end
    return f;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 8; i++) begin
          m_reg[c][i]  <= '0;
          m_busy[c][i] <= 1'b0;
        end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (RFWrite && usable(c, regw)) begin
          m_reg[c][regw]  <= dataw & mask(c);
          m_busy[c][regw] <= 1'b0;
        end
        if (mark && usable(c, mark_reg))
          m_busy[c][mark_reg] <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [127:0] act_d1 [3], act_d2 [3], act_fl [3];
  logic         act_b1 [3], act_b2 [3];
  assign act_d1[0] = 128'(d1_a);
  assign act_d1[1] = 128'(d1_b);
  assign act_d1[2] = 128'(d1_c);
  assign act_d2[0] = 128'(d2_a);
  assign act_d2[1] = 128'(d2_b);
  assign act_d2[2] = 128'(d2_c);
  assign act_b1[0] = b1_a;
  assign act_b1[1] = b1_b;
  assign act_b1[2] = b1_c;
  assign act_b2[0] = b2_a;
  assign act_b2[1] = b2_b;
  assign act_b2[2] = b2_c;
  assign act_fl[0] = rf_a;
  assign act_fl[1] = rf_b;
  assign act_fl[2] = 128'(rf_c);

  // The single per-cycle compare process against the model.
  always @(negedge clock) begin
    for (int c = 0; c < 3; c++) begin
      check($sformatf("cyc cfg%0d data1", c), act_d1[c], 128'(exp_data(c, reg1)));
      check($sformatf("cyc cfg%0d data2", c), act_d2[c], 128'(exp_data(c, reg2)));
      check($sformatf("cyc cfg%0d busy1", c), 128'(act_b1[c]), 128'(exp_busy(c, reg1)));
      check($sformatf("cyc cfg%0d busy2", c), 128'(act_b2[c]), 128'(exp_busy(c, reg2)));
      check($sformatf("cyc cfg%0d regs_flat", c), act_fl[c], exp_flat(c));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    RFWrite = 1'b0;
    mark = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #2 reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    #2;
    check("reset a regs_flat", rf_a, 128'h0);
    check("reset a busy1", 128'(b1_a), 128'h0);
    cyc();

    // Write/read: R5 = 0xBEEF, absent in cfg 2.
    RFWrite = 1'b1; regw = 3'd5; dataw = 16'hBEEF;
    cyc(); idle();
    reg1 = 3'd5; reg2 = 3'd5;
    #2;
    check("wr a data1", 128'(d1_a), 128'hBEEF);
    check("wr a data2", 128'(d2_a), 128'hBEEF);
    check("wr b data1", 128'(d1_b), 128'hBEEF);
    check("wr c data1 absent", 128'(d1_c), 128'h0);

    // Bypass: R3 = 0x11, then write 0x22 while reading R3.
    cyc();
    RFWrite = 1'b1; regw = 3'd3; dataw = 16'h0011;
    cyc();
    dataw = 16'h0022; reg1 = 3'd3;
    #2;
    check("byp a pre-edge", 128'(d1_a), 128'h11);
    check("byp b pre-edge", 128'(d1_b), 128'h22);
    check("byp c pre-edge", 128'(d1_c), 128'h22);
    cyc(); idle();
    #2;
    check("byp a post-edge", 128'(d1_a), 128'h22);

    // Scoreboard on R2.
    cyc();
    mark = 1'b1; mark_reg = 3'd2; reg1 = 3'd2;
    cyc(); idle();
    #2;
    check("sb a busy after mark", 128'(b1_a), 128'h1);
    check("sb b busy after mark", 128'(b1_b), 128'h1);
    RFWrite = 1'b1; regw = 3'd2; dataw = 16'h0007;
    #1;
    check("sb a busy pre-write", 128'(b1_a), 128'h1);
    check("sb b busy bypass", 128'(b1_b), 128'h0);
    cyc(); idle();
    #2;
    check("sb a busy after write", 128'(b1_a), 128'h0);
    check("sb a data after write", 128'(d1_a), 128'h7);
    RFWrite = 1'b1; regw = 3'd2; dataw = 16'h0007; mark = 1'b1; mark_reg = 3'd2;
    cyc(); idle();
    #2;
    check("sb a mark+write busy", 128'(b1_a), 128'h1);
    check("sb a mark+write data", 128'(d1_a), 128'h7);
    check("sb c mark+write busy", 128'(b1_c), 128'h1);

    // Mark and write on different registers on the same edge.
    RFWrite = 1'b1; regw = 3'd1; dataw = 16'h0033; mark = 1'b1; mark_reg = 3'd4;
    reg1 = 3'd1; reg2 = 3'd4;
    cyc(); idle();
    #2;
    check("split a data1", 128'(d1_a), 128'h33);
    check("split a busy1", 128'(b1_a), 128'h0);
    check("split a busy2", 128'(b2_a), 128'h1);

    // ZERO_R0: write and mark R0.
    RFWrite = 1'b1; regw = 3'd0; dataw = 16'h00FF; mark = 1'b1; mark_reg = 3'd0;
    reg1 = 3'd0;
    #1;
    check("z0 b data1 pre-edge", 128'(d1_b), 128'h0);
    check("z0 b busy1 pre-edge", 128'(b1_b), 128'h0);
    cyc(); idle();
    #2;
    check("z0 b data1", 128'(d1_b), 128'h0);
    check("z0 b busy1", 128'(b1_b), 128'h0);
    check("z0 b flat R0", 128'(rf_b[15:0]), 128'h0);
    check("z0 a data1", 128'(d1_a), 128'hFF);
    check("z0 a busy1", 128'(b1_a), 128'h1);

    // Out-of-range addresses on the 5-register file.
    RFWrite = 1'b1; regw = 3'd6; dataw = 16'h00AB; reg1 = 3'd7;
    #1;
    check("oor c data1", 128'(d1_c), 128'h0);
    check("oor c busy1", 128'(b1_c), 128'h0);
    cyc(); idle();
    #2;
    check("oor c flat", 128'(rf_c), 128'h00_22_07_33_FF);

    // Async reset mid-cycle, after loading R1 = 0x5A.
    RFWrite = 1'b1; regw = 3'd1; dataw = 16'h005A;
    cyc(); idle();
    reg1 = 3'd1; reg2 = 3'd2;
    #2;
    check("rst a data1 before", 128'(d1_a), 128'h5A);
    check("rst a busy2 before", 128'(b2_a), 128'h1);
    reset = 1'b0;
    #1;
    check("rst a data1", 128'(d1_a), 128'h0);
    check("rst a data2", 128'(d2_a), 128'h0);
    check("rst a busy2", 128'(b2_a), 128'h0);
    check("rst a flat", rf_a, 128'h0);
    check("rst b flat", rf_b, 128'h0);
    check("rst c flat", 128'(rf_c), 128'h0);
    // Reset dominates a write and a mark.
    RFWrite = 1'b1; regw = 3'd1; mark = 1'b1; mark_reg = 3'd2;
    cyc(); cyc();
    #1;
    check("rst dominates a data1", 128'(d1_a), 128'h0);
    check("rst dominates a busy2", 128'(b2_a), 128'h0);
    idle();
    reset = 1'b1;

    // Random traffic checked by the per-cycle compare process.
    for (int n = 0; n < 300; n++) begin
      cyc();
      reg1     = 3'($urandom_range(7));
      reg2     = 3'($urandom_range(7));
      regw     = 3'($urandom_range(7));
      mark_reg = 3'($urandom_range(7));
      dataw    = 16'($urandom);
      RFWrite  = 1'($urandom_range(1));
      mark     = ($urandom_range(3) == 0);
    end
    cyc(); idle();
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
